rr_arb4: RTL and testbench
==========================

RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner when preemption is compiled in (legal 2..255).
REQ-002 SHALL have port CLK input 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST input 1: reset, synchronous, active-high.
REQ-004 SHALL have port REQ input 4: request lines; REQ[i] high = requester i wants the shared resource.
REQ-005 SHALL have port GNT output 4: registered grant, one-hot or all-zero.
REQ-006 SHALL have port GNT_ID output 2: binary index of current owner; 2'b00 when GNT is zero.
REQ-007 SHALL have port BUSY output 1: high whenever GNT is non-zero.

Function
REQ-008 SHALL implement two states: IDLE (no owner) and OWNED (exactly one GNT bit high).
REQ-009 SHALL hold a 2-bit priority pointer PTR; search order is PTR, PTR+1, PTR+2, PTR+3 (mod 4).
REQ-010 IDLE: if REQ non-zero at an edge, SHALL grant the first requesting index in search order at that edge (GNT visible 1 cycle after REQ sampled); go OWNED.
REQ-011 IDLE with REQ=0 SHALL stay IDLE, GNT=0.
REQ-012 OWNED: while REQ[owner]=1 (and no preemption), GNT SHALL remain unchanged.
REQ-013 OWNED: when REQ[owner]=0 is sampled, SHALL set PTR=owner+1 mod 4 and, in the same edge, grant the next requester in the new search order (zero-bubble handoff) or go IDLE with GNT=0 if none.
REQ-014 The releasing owner SHALL never be regranted at the release edge (its REQ is low by definition).
REQ-015 A requester dropping REQ before being granted SHALL lose nothing else; no request latching inside the block.
REQ-016 GNT SHALL never have more than one bit set; GNT_ID SHALL always equal the encoded GNT; BUSY SHALL equal |GNT.
REQ-017 SHALL hold a hold counter HCNT, cleared on every new grant, incremented each OWNED cycle, saturating at MAX_HOLD-1.
REQ-018 Starvation bound with preemption: any asserted request SHALL be granted within 3*MAX_HOLD+3 cycles.

Reset
REQ-019 RST high at an edge SHALL force IDLE, GNT=4'b0000, GNT_ID=2'b00, BUSY=0, PTR=2'b00, HCNT=0, overriding all other inputs.
REQ-020 Reset asserted mid-ownership SHALL drop the grant at that edge with no handoff; first grant after reset release follows REQ-010 from PTR=0.

Configuration
REQ-021 Macro RR_ARB4_PREEMPT_EN SHALL control hold-time preemption.
REQ-022 With RR_ARB4_PREEMPT_EN defined: when HCNT=MAX_HOLD-1 and some REQ[j]=1 with j!=owner, SHALL at that edge set PTR=owner+1 mod 4 and grant the next requester in search order excluding owner; if no other request, owner keeps grant and HCNT stays saturated.
REQ-023 Without RR_ARB4_PREEMPT_EN: HCNT and preemption logic SHALL be absent; owner keeps grant until it drops REQ; MAX_HOLD is ignored; REQ-018 does not apply.

Verification
REQ-024 Reset then REQ=4'b1010 held -> GNT=4'b0010, GNT_ID=1, BUSY=1 one cycle after sampling; stable while REQ[1]=1.
REQ-025 Owner 1 drops REQ with REQ[3]=1 -> next cycle GNT=4'b1000, GNT_ID=3, BUSY never low; then REQ=0 -> GNT=0, IDLE.
REQ-026 All four REQ high, each owner drops after 2 cycles and reasserts -> grant order 0,1,2,3,0; one-hot checked every cycle.
REQ-027 PREEMPT_EN, MAX_HOLD=4, REQ=4'b0101 held -> owner 0 for 4 cycles, then GNT=4'b0100 for 4 cycles, then back to 4'b0001; REQ=4'b0001 alone -> owner 0 held indefinitely.
REQ-028 RST asserted for 1 cycle while GNT=4'b0100 -> next cycle GNT=0, PTR=0; REQ=4'b1111 afterwards -> GNT=4'b0001.
REQ-029 Without PREEMPT_EN, MAX_HOLD=4, REQ=4'b0011 held 20 cycles -> GNT=4'b0001 all 20 cycles.

Source files
------------

// File: rtl/rr_arb4.sv
// rr_arb4 -- four-way round-robin arbiter with registered, one-hot grant.
//
// Ports:
//   CLK     rising-edge clock for all state
//   RST     synchronous active-high reset (IDLE, no grant, PTR=0)
//   REQ     request lines, REQ[i]=1 means requester i wants the resource
//   GNT     registered grant, one-hot or all-zero
//   GNT_ID  binary index of the current owner, 2'b00 when GNT is zero
//   BUSY    high whenever GNT is non-zero
//
// Parameter:
//   MAX_HOLD  consecutive grant cycles per owner before preemption (2..255);
//             only meaningful when RR_ARB4_PREEMPT_EN is defined.
//
// Configuration macro:
//   RR_ARB4_PREEMPT_EN  enables hold-time preemption via the HCNT counter.
//                       Undefined: the owner keeps the grant until it drops REQ.
module rr_arb4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb4: MAX_HOLD must be within 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;

  // {found, index} of the first set bit of mask, scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] cand;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!res[2] && mask[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  logic [1:0] ptr_after;   // pointer value once the current owner is rotated past
  logic [2:0] idle_pick;   // choice from IDLE using the stored pointer
  logic [2:0] rel_pick;    // choice at a release edge using the rotated pointer

  always_comb begin
    ptr_after = GNT_ID + 2'd1;
    idle_pick = rr_pick(REQ, ptr);
    rel_pick  = rr_pick(REQ, ptr_after);
  end

`ifdef RR_ARB4_PREEMPT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hcnt;
  logic [3:0] other_req;
  logic [2:0] pre_pick;

  always_comb begin
    other_req = REQ & ~GNT;
    pre_pick  = rr_pick(other_req, ptr_after);
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      ptr    <= '0;
      GNT    <= '0;
      GNT_ID <= '0;
      BUSY   <= 1'b0;
`ifdef RR_ARB4_PREEMPT_EN
      hcnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick[2]) begin
            state  <= OWNED;
            GNT    <= 4'b0001 << idle_pick[1:0];
            GNT_ID <= idle_pick[1:0];
            BUSY   <= 1'b1;
`ifdef RR_ARB4_PREEMPT_EN
            hcnt   <= '0;
`endif
          end
        end
        OWNED: begin
          if (!REQ[GNT_ID]) begin
            // Release: rotate past the owner and hand off in the same edge.
            // The owner's own REQ is low here, so it cannot be regranted.
            ptr <= ptr_after;
            if (rel_pick[2]) begin
              GNT    <= 4'b0001 << rel_pick[1:0];
              GNT_ID <= rel_pick[1:0];
            end else begin
              state  <= IDLE;
              GNT    <= '0;
              GNT_ID <= '0;
              BUSY   <= 1'b0;
            end
`ifdef RR_ARB4_PREEMPT_EN
            hcnt <= '0;
          end else if (hcnt == HOLD_LAST && pre_pick[2]) begin
            // Hold limit reached with a competitor waiting: owner is masked out.
            ptr    <= ptr_after;
            GNT    <= 4'b0001 << pre_pick[1:0];
            GNT_ID <= pre_pick[1:0];
            hcnt   <= '0;
          end else if (hcnt != HOLD_LAST) begin
            hcnt <= hcnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb4.sv
module tb_rr_arb4;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  rr_arb4 #(.MAX_HOLD(HOLD)) dut (
    .CLK    (clk),
    .RST    (rst),
    .REQ    (req),
    .GNT    (gnt),
    .GNT_ID (gnt_id),
    .BUSY   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner = -1 means idle.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hcnt  = 0;

  logic [6:0] exp_q[$];   // {gnt, gnt_id, busy}

  function automatic int first_from(input logic [3:0] mask, input int start);
    for (int k = 0; k < 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q);
    logic [3:0] others;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_hcnt = 0;
    end else if (m_owner < 0) begin
      if (q != 4'b0000) begin
        m_owner = first_from(q, m_ptr);
        m_hcnt  = 0;
      end
    end else if (!q[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = first_from(q, m_ptr);
      m_hcnt  = 0;
    end else begin
`ifdef RR_ARB4_PREEMPT_EN
      others = q & ~(4'b0001 << m_owner);
      if (m_hcnt == HOLD - 1 && others != 4'b0000) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = first_from(others, m_ptr);
        m_hcnt  = 0;
      end else if (m_hcnt < HOLD - 1) begin
        m_hcnt++;
      end
`else
      others = '0;
`endif
    end
    if (m_owner < 0) exp_q.push_back(7'b0);
    else exp_q.push_back({4'b0001 << m_owner, 2'(m_owner), 1'b1});
  endtask

  // Drive one cycle of inputs, let the model predict at the edge, compare at negedge.
  task automatic step(input logic r, input logic [3:0] q);
    logic [6:0] e;
    rst = r;
    req = q;
    @(posedge clk);
    model_step(r, q);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("gnt", 32'(gnt), 32'(e[6:3]));
      check("gnt_id", 32'(gnt_id), 32'(e[2:1]));
      check("busy", 32'(busy), 32'(e[0]));
      check("onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    @(negedge clk);

    // Reset state
    step(1'b1, 4'b0000);
    step(1'b1, 4'b1111);
    check("reset_gnt", 32'(gnt), 32'h0);

    // Lowest index after PTR=0 wins, stable while held
    step(1'b0, 4'b1010);
    check("r024_gnt", 32'(gnt), 32'h2);
    check("r024_id", 32'(gnt_id), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1010);
    check("r024_hold", 32'(gnt), 32'h2);

    // Zero-bubble handoff to 3, then idle
    step(1'b0, 4'b1000);
    check("r025_gnt", 32'(gnt), 32'h8);
    check("r025_busy", 32'(busy), 32'd1);
    step(1'b0, 4'b0000);
    check("r025_idle", 32'(gnt), 32'h0);

    // Full rotation with all requesters active
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1111);
    for (int r = 0; r < 5; r++) begin
      check($sformatf("r026_owner%0d", r), 32'(gnt), 32'(4'b0001 << (r % 4)));
      step(1'b0, 4'b1111);
      step(1'b0, 4'hF & ~(4'b0001 << (r % 4)));
    end

    // Reset mid-ownership drops grant; next grant starts from PTR=0
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    check("r028_pre", 32'(gnt), 32'h4);
    step(1'b1, 4'b0100);
    check("r028_rst", 32'(gnt), 32'h0);
    step(1'b0, 4'b1111);
    check("r028_after", 32'(gnt), 32'h1);

    step(1'b1, 4'b0000);
`ifdef RR_ARB4_PREEMPT_EN
    // Preemption alternates 0 and 2 every HOLD cycles; lone owner held
    for (int i = 0; i < 3 * HOLD; i++) begin
      step(1'b0, 4'b0101);
      check($sformatf("r027_c%0d", i), 32'(gnt), ((i / HOLD) % 2 == 0) ? 32'h1 : 32'h4);
    end
    step(1'b1, 4'b0000);
    for (int i = 0; i < 3 * HOLD; i++) begin
      step(1'b0, 4'b0001);
      check($sformatf("r027_solo%0d", i), 32'(gnt), 32'h1);
    end
`else
    // No preemption: owner 0 held for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0011);
      check($sformatf("r029_c%0d", i), 32'(gnt), 32'h1);
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 31) == 0), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
